fp_normalize_pipe: RTL and testbench
====================================

// Module: fp_normalize_pipe
// PURPOSE
//  Parametrised, 2-stage pipelined post-add normaliser for the FP adder path.
//  Takes a raw mantissa sum (carry|hidden|fraction|G,R,S) plus a biased exponent.
//  Produces a normalised, RNE-rounded fraction with the adjusted exponent and exception flags.
//  Sits between the mantissa adder and the FP result mux; valid/ready on both sides.
// PARAMETERS
//  MANT_W   23   stored fraction bits (hidden bit excluded)
//  EXP_W    8    biased exponent bits
//  W        MANT_W+5 (localparam) input mantissa width: [W-1]=carry, [W-2]=hidden, [2:0]=G,R,S
//  SH_W     $clog2(W)+1 (localparam) signed shift-report width
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        input beat valid
//  in_ready   out  1        block can accept a beat this cycle
//  in_sign    in   1        result sign, passed through
//  in_exp     in   EXP_W    biased exponent before normalisation
//  in_mant    in   W        raw mantissa sum with guard/round/sticky
//  out_valid  out  1        output beat valid
//  out_ready  in   1        downstream accepts output beat
//  out_sign   out  1        sign (forced 0 only when in_mant==0)
//  out_exp    out  EXP_W    adjusted biased exponent
//  out_frac   out  MANT_W   rounded fraction, hidden bit dropped
//  out_shift  out  SH_W     signed normalise shift: -1 right, 0 none, k>0 left by k
//  out_zero   out  1        result is exact zero
//  out_of     out  1        exponent overflow, result forced to inf
//  out_uf     out  1        exponent underflow, result flushed to zero
//  out_inexact out 1        any of G/R/S (after shift) nonzero
// BEHAVIOUR
//  Reset: s1_valid=s2_valid=0; all outputs and pipeline regs 0; in_ready=1 after reset.
//  Handshake: beat transfers when valid&&ready. out_valid=s2_valid. s2 loads when !s2_valid||out_ready.
//   in_ready = !s1_valid || s2 loads. Throughput 1/cycle, latency 2 cycles, no bubbles, order kept.
//  Outputs are registered and stable while out_valid&&!out_ready.
//  Stage 1: leading-one detect over in_mant; register shift amount, zero flag, sign, exp, mant.
//   in_mant[W-1]=1 -> shift=-1; else in_mant[W-2]=1 -> 0; else shift=(W-2)-index of MS one.
//  Stage 2: shift + exponent adjust + round + flags.
//   shift=-1: mant>>1, bit shifted out ORed into sticky, exp+1.
//   shift=k>0: mant<<k, zero fill, exp-k; computed at EXP_W+2 bits signed, no wrap.
//   RNE: round up iff G && (R||S||LSB); inexact = G|R|S.
//   Round carry out of hidden bit -> frac=0, exp+1 (recheck overflow).
//   Adjusted exp >= 2^EXP_W-1 -> out_exp all ones, frac 0, of=1, inexact=1.
//   Adjusted exp <= 0 (no subnormals) -> exp 0, frac 0, uf=1, inexact=1, sign kept.
//   in_mant==0 -> zero=1, exp 0, frac 0, shift 0, sign 0; no flags.
//  Simultaneous in/out transfer with both stages full: advance both, no loss.
//  rst_n low mid-stall: valids drop immediately (async); in-flight beats discarded.
// STRUCTURE
//  Package fp_norm_pkg: MANT_W/EXP_W defaults, W/SH_W derivation functions, GRS bit-index
//   constants, EXP_MAX constant, flag struct typedef.
//  Sub-module fp_lzc (parametrised leading-zero counter, combinational, W bits) used in stage 1.
//  Everything else inline: two register stages plus valid/ready control.
// TESTING (MANT_W=23, EXP_W=8, W=28, out_ready=1 unless stated)
//  1 in_mant=28'h8000000, exp=127 -> 2 cycles later exp=128, frac=0, shift=-1, flags 0.
//  2 in_mant=28'h4000008, exp=127 -> frac=23'h000001, exp=127, shift=0, inexact=0.
//  3 in_mant=28'h0000100, exp=100 -> shift=18, exp=82, frac=0; same with exp=10 -> uf=1, exp=0.
//  4 in_mant=28'h7FFFFFC, exp=127 -> frac=0, exp=128, inexact=1; exp=254 -> of=1, exp=8'hFF.
//  5 in_mant=0 -> out_zero=1, exp=0, frac=0, sign=0; inexact=0.
//  6 out_ready=0, 3 back-to-back beats -> in_ready low after 2 held; release -> all 3 out in order;
//    assert rst_n mid-stall -> out_valid=0 at once, in_ready=1 after release.

Source files
------------

// File: rtl/fp_norm_pkg.sv
// Shared parameters, width helpers, GRS bit positions and flag bundle for the FP normaliser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_norm_pkg;

  localparam int MANT_W_DEF = 23;
  localparam int EXP_W_DEF  = 8;

  // Bit positions within the normalised mantissa (fraction LSB sits just above G).
  localparam int LSB_IDX = 3;
  localparam int G_IDX   = 2;
  localparam int R_IDX   = 1;
  localparam int S_IDX   = 0;

  localparam int EXP_MAX = (1 << EXP_W_DEF) - 1;

  function automatic int calc_w(input int mant_w);
    return mant_w + 5;
  endfunction

  function automatic int calc_sh_w(input int w);
    return $clog2(w) + 1;
  endfunction

  function automatic int calc_exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  typedef struct packed {
    logic zero;
    logic of;
    logic uf;
    logic inexact;
  } fp_flags_t;

endpackage

// File: rtl/fp_normalize_pipe_lzc.sv
// Leading-zero counter over a W-bit vector; returns W when the vector is all zero.
// Latency: combinational.
// Backpressure: none.
// Ports: i_dat - vector to scan, o_cnt - number of zeros above the most significant one.
module fp_lzc #(
  parameter  int W     = 28,
  localparam int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     i_dat,
  output logic [CNT_W-1:0] o_cnt
);

  // Scan upward so the highest set bit is the last one to assign.
  always_comb begin
    o_cnt = CNT_W'(W);
    for (int i = 0; i < W; i++) begin
      if (i_dat[i]) o_cnt = CNT_W'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_normalize_pipe.sv
// Post-add normaliser: leading-one detect, shift, exponent adjust, RNE round, exception flags.
// Latency: 2 cycles, 1 beat/cycle throughput.
// Backpressure: in_ready follows stage occupancy and out_ready; outputs held while stalled.
// Ports: in_valid/in_ready/in_sign/in_exp/in_mant (carry|hidden|fraction|G,R,S) upstream;
//        out_valid/out_ready/out_sign/out_exp/out_frac/out_shift and zero/of/uf/inexact flags downstream.
module fp_normalize_pipe
  import fp_norm_pkg::*;
#(
  parameter  int MANT_W = MANT_W_DEF,
  parameter  int EXP_W  = EXP_W_DEF,
  localparam int W      = calc_w(MANT_W),
  localparam int SH_W   = calc_sh_w(calc_w(MANT_W))
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [W-1:0]      in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_frac,
  output logic [SH_W-1:0]   out_shift,
  output logic              out_zero,
  output logic              out_of,
  output logic              out_uf,
  output logic              out_inexact
);

  localparam int CNT_W = $clog2(W + 1);
  localparam int XW    = EXP_W + 2;
  localparam logic [EXP_W:0] EXP_TOP = (EXP_W + 1)'(calc_exp_max(EXP_W));

  // ---------------- stage 1: leading-one detect ----------------
  logic [CNT_W-1:0] w_lzc;
  logic             w_in_zero;
  logic [SH_W-1:0]  w_in_shift;

  fp_lzc #(.W(W)) u_lzc (
    .i_dat (in_mant),
    .o_cnt (w_lzc)
  );

  // Hidden position is one below the carry, so shift = lzc-1 covers all three cases
  // (carry -> -1, hidden -> 0, lower -> left by k).
  assign w_in_zero  = ~|in_mant;
  assign w_in_shift = w_in_zero ? '0 : (SH_W'(w_lzc) - SH_W'(1));

  logic              r_s1_vld;
  logic              r_s1_sign;
  logic [EXP_W-1:0]  r_s1_exp;
  logic [W-1:0]      r_s1_mant;
  logic [SH_W-1:0]   r_s1_shift;
  logic              r_s1_zero;

  // ---------------- stage 2: shift, round, flags ----------------
  logic              w_s2_load;
  logic [W-3:0]      w_mant_n;   // fraction + G,R,S after normalising
  logic [XW-1:0]     w_shift_ext;
  logic [XW-1:0]     w_exp_sh;
  logic [XW-1:0]     w_exp_fin;
  logic              w_g, w_r, w_s, w_lsb, w_rnd_up, w_rnd_cy;
  logic [MANT_W-1:0] w_frac_rnd;
  logic              w_of, w_uf;
  logic              w_sign_n;
  logic [EXP_W-1:0]  w_exp_n;
  logic [MANT_W-1:0] w_frac_n;
  fp_flags_t         w_flags_n;

  always_comb begin
    // Right shift folds the dropped bit into sticky; left shift zero-fills.
    if (r_s1_shift[SH_W-1]) w_mant_n = {r_s1_mant[W-2:2], |r_s1_mant[1:0]};
    else                    w_mant_n = (W-2)'(r_s1_mant << r_s1_shift);

    // Exponent is carried two bits wider and signed so underflow/overflow never wrap.
    w_shift_ext = {{(XW-SH_W){r_s1_shift[SH_W-1]}}, r_s1_shift};
    w_exp_sh    = {2'b00, r_s1_exp} - w_shift_ext;

    w_g      = w_mant_n[G_IDX];
    w_r      = w_mant_n[R_IDX];
    w_s      = w_mant_n[S_IDX];
    w_lsb    = w_mant_n[LSB_IDX];
    w_rnd_up = w_g & (w_r | w_s | w_lsb);

    // Hidden bit is always 1 here, so a carry out of the fraction is a carry out of the hidden bit.
    {w_rnd_cy, w_frac_rnd} = {1'b0, w_mant_n[W-3:3]} + (MANT_W+1)'(w_rnd_up);
    w_exp_fin = w_exp_sh + XW'(w_rnd_cy);

    w_uf = w_exp_fin[XW-1] | (w_exp_fin == '0);
    w_of = ~w_exp_fin[XW-1] & (w_exp_fin[EXP_W:0] >= EXP_TOP);

    w_sign_n          = r_s1_sign;
    w_exp_n           = w_exp_fin[EXP_W-1:0];
    w_frac_n          = w_frac_rnd;
    w_flags_n         = '0;
    w_flags_n.inexact = w_g | w_r | w_s;

    if (r_s1_zero) begin
      w_sign_n  = 1'b0;
      w_exp_n   = '0;
      w_frac_n  = '0;
      w_flags_n = '0;
      w_flags_n.zero = 1'b1;
    end else if (w_of) begin
      w_exp_n           = '1;
      w_frac_n          = '0;
      w_flags_n.of      = 1'b1;
      w_flags_n.inexact = 1'b1;
    end else if (w_uf) begin
      w_exp_n           = '0;
      w_frac_n          = '0;
      w_flags_n.uf      = 1'b1;
      w_flags_n.inexact = 1'b1;
    end
  end

  // ---------------- handshake and registers ----------------
  logic              r_s2_vld;
  logic              r_s2_sign;
  logic [EXP_W-1:0]  r_s2_exp;
  logic [MANT_W-1:0] r_s2_frac;
  logic [SH_W-1:0]   r_s2_shift;
  fp_flags_t         r_s2_flags;

  assign w_s2_load = ~r_s2_vld | out_ready;
  assign in_ready  = ~r_s1_vld | w_s2_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_exp   <= '0;
      r_s1_mant  <= '0;
      r_s1_shift <= '0;
      r_s1_zero  <= 1'b0;
      r_s2_vld   <= 1'b0;
      r_s2_sign  <= 1'b0;
      r_s2_exp   <= '0;
      r_s2_frac  <= '0;
      r_s2_shift <= '0;
      r_s2_flags <= '0;
    end else begin
      if (in_ready) begin
        r_s1_vld <= in_valid;
        if (in_valid) begin
          r_s1_sign  <= in_sign;
          r_s1_exp   <= in_exp;
          r_s1_mant  <= in_mant;
          r_s1_shift <= w_in_shift;
          r_s1_zero  <= w_in_zero;
        end
      end
      if (w_s2_load) begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_s2_sign  <= w_sign_n;
          r_s2_exp   <= w_exp_n;
          r_s2_frac  <= w_frac_n;
          r_s2_shift <= r_s1_shift;
          r_s2_flags <= w_flags_n;
        end
      end
    end
  end

  assign out_valid   = r_s2_vld;
  assign out_sign    = r_s2_sign;
  assign out_exp     = r_s2_exp;
  assign out_frac    = r_s2_frac;
  assign out_shift   = r_s2_shift;
  assign out_zero    = r_s2_flags.zero;
  assign out_of      = r_s2_flags.of;
  assign out_uf      = r_s2_flags.uf;
  assign out_inexact = r_s2_flags.inexact;

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Scoreboard bench for fp_normalize_pipe with MANT_W=23, EXP_W=8.
// Latency: n/a.
// Backpressure: drives out_ready low to exercise stall and mid-stall reset.
module tb_fp_normalize_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [27:0] in_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_frac;
  logic [5:0]  out_shift;
  logic        out_zero, out_of, out_uf, out_inexact;

  always #5 clk = ~clk;

  fp_normalize_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_exp(out_exp),
    .out_frac(out_frac), .out_shift(out_shift), .out_zero(out_zero), .out_of(out_of),
    .out_uf(out_uf), .out_inexact(out_inexact)
  );

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic [5:0]  shift;
    logic        zero;
    logic        of;
    logic        uf;
    logic        inx;
  } res_t;

  res_t exp_q[$];
  res_t mon_exp;
  res_t act;
  int   checks = 0;
  int   errors = 0;

  localparam int NV = 14;
  logic        v_sign[NV];
  logic [7:0]  v_exp[NV];
  logic [27:0] v_mant[NV];
  res_t        v_res[NV];

  function automatic res_t mk(input logic s, input logic [7:0] e, input logic [22:0] f,
                              input logic [5:0] sh, input logic z, input logic o,
                              input logic u, input logic x);
    res_t r;
    r = {s, e, f, sh, z, o, u, x};
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] a, input logic [63:0] r);
    checks++;
    if (a !== r) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, a, r);
    end
  endtask

  // Monitor: settles after the negedge drives, then scores any beat that will transfer at the next posedge.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      act = {out_sign, out_exp, out_frac, out_shift, out_zero, out_of, out_uf, out_inexact};
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'(act), 64'hDEAD);
      end else begin
        mon_exp = exp_q.pop_front();
        check("beat", 64'(act), 64'(mon_exp));
      end
    end
  end

  task automatic send(input int idx);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = v_sign[idx];
    in_exp   = v_exp[idx];
    in_mant  = v_mant[idx];
    while (!got && n < 50) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        exp_q.push_back(v_res[idx]);
        got = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout idx=%0d actual=in_ready_low required=accept", idx);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    v_sign[0]  = 0; v_exp[0]  = 8'd127; v_mant[0]  = 28'h8000000; v_res[0]  = mk(0, 8'd128, 23'd0, 6'h3F, 0, 0, 0, 0);
    v_sign[1]  = 1; v_exp[1]  = 8'd127; v_mant[1]  = 28'h4000008; v_res[1]  = mk(1, 8'd127, 23'd1, 6'd0,  0, 0, 0, 0);
    v_sign[2]  = 0; v_exp[2]  = 8'd100; v_mant[2]  = 28'h0000100; v_res[2]  = mk(0, 8'd82,  23'd0, 6'd18, 0, 0, 0, 0);
    v_sign[3]  = 1; v_exp[3]  = 8'd10;  v_mant[3]  = 28'h0000100; v_res[3]  = mk(1, 8'd0,   23'd0, 6'd18, 0, 0, 1, 1);
    v_sign[4]  = 0; v_exp[4]  = 8'd127; v_mant[4]  = 28'h7FFFFFC; v_res[4]  = mk(0, 8'd128, 23'd0, 6'd0,  0, 0, 0, 1);
    v_sign[5]  = 0; v_exp[5]  = 8'd254; v_mant[5]  = 28'h7FFFFFC; v_res[5]  = mk(0, 8'hFF,  23'd0, 6'd0,  0, 1, 0, 1);
    v_sign[6]  = 1; v_exp[6]  = 8'd50;  v_mant[6]  = 28'h0000000; v_res[6]  = mk(0, 8'd0,   23'd0, 6'd0,  1, 0, 0, 0);
    v_sign[7]  = 0; v_exp[7]  = 8'd127; v_mant[7]  = 28'h4000004; v_res[7]  = mk(0, 8'd127, 23'd0, 6'd0,  0, 0, 0, 1);
    v_sign[8]  = 0; v_exp[8]  = 8'd127; v_mant[8]  = 28'h400000C; v_res[8]  = mk(0, 8'd127, 23'd2, 6'd0,  0, 0, 0, 1);
    v_sign[9]  = 0; v_exp[9]  = 8'd127; v_mant[9]  = 28'h8000001; v_res[9]  = mk(0, 8'd128, 23'd0, 6'h3F, 0, 0, 0, 1);
    v_sign[10] = 0; v_exp[10] = 8'd127; v_mant[10] = 28'h2000001; v_res[10] = mk(0, 8'd126, 23'd0, 6'd1,  0, 0, 0, 1);
    v_sign[11] = 0; v_exp[11] = 8'd254; v_mant[11] = 28'h8000000; v_res[11] = mk(0, 8'hFF,  23'd0, 6'h3F, 0, 1, 0, 1);
    v_sign[12] = 0; v_exp[12] = 8'd18;  v_mant[12] = 28'h0000100; v_res[12] = mk(0, 8'd0,   23'd0, 6'd18, 0, 0, 1, 1);
    v_sign[13] = 0; v_exp[13] = 8'd19;  v_mant[13] = 28'h0000100; v_res[13] = mk(0, 8'd1,   23'd0, 6'd18, 0, 0, 0, 0);

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_outputs", 64'({out_sign, out_exp, out_frac, out_shift, out_zero, out_of, out_uf, out_inexact}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors, back to back at full rate
    for (int i = 0; i < NV; i++) send(i);
    idle();
    drain();

    // Stall: out_ready low, three beats offered
    out_ready = 1'b0;
    send(0);
    send(1);
    fork
      send(2);
      begin
        repeat (2) @(negedge clk);
        #1;
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_held_exp", 64'({out_exp, out_shift}), 64'({8'd128, 6'h3F}));
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    idle();
    drain();

    // Async reset in the middle of a stall
    out_ready = 1'b0;
    send(4);
    send(5);
    idle();
    repeat (2) @(negedge clk);
    #1;
    check("prerst_out_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("postrst_in_ready", 64'(in_ready), 64'd1);
    check("postrst_out_valid", 64'(out_valid), 64'd0);
    send(8);
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
